// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC engine.
// Angles are radians in signed Q2.x fixed point.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // 1/K in Q2.30; callers pre-scale x_in by this for unit-amplitude sin/cos.
  localparam logic [31:0] INV_K_Q30 = 32'h26DD3B6A;

  // atan(2^-i) in Q2.30, rounded to nearest.
  localparam logic [31:0] ATAN_Q30 [32] = '{
    32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7,
    32'h03FEAB77, 32'h01FFD55C, 32'h00FFFAAB, 32'h007FFF55,
    32'h003FFFEB, 32'h001FFFFD, 32'h00100000, 32'h00080000,
    32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000,
    32'h00004000, 32'h00002000, 32'h00001000, 32'h00000800,
    32'h00000400, 32'h00000200, 32'h00000100, 32'h00000080,
    32'h00000040, 32'h00000020, 32'h00000010, 32'h00000008,
    32'h00000004, 32'h00000002, 32'h00000001, 32'h00000000
  };

  // Entry i requantised to Q2.(width-2), rounding half up on the dropped bits.
  function automatic logic [31:0] atan_entry(input int i, input int width);
    logic [32:0] full;
    logic [32:0] rounded;
    full = {1'b0, ATAN_Q30[i[4:0]]};
    if (width >= 32) begin
      rounded = full;
    end else begin
      rounded = (full + (33'd1 << (31 - width))) >> (32 - width);
    end
    return rounded[31:0];
  endfunction

endpackage

// File: rtl/cordic_ashift.sv
// Combinational arithmetic right shift by a runtime amount (din >>> shamt).
module ashift #(
  parameter int WIDTH   = 16,
  parameter int SHIFT_W = 4
) (
  input  logic [WIDTH-1:0]   din,
  input  logic [SHIFT_W-1:0] shamt,
  output logic [WIDTH-1:0]   dout
);

  assign dout = $unsigned($signed(din) >>> shamt);

endmodule

// File: rtl/cordic_engine.sv
// Iterative CORDIC: one micro-rotation per clock, rotation or vectoring mode,
// start/done handshake. Gain K is left uncompensated.
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = 14
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0] x_shift, y_shift, atan_val;
  logic             rotate_pos;

  ashift #(.WIDTH(WIDTH), .SHIFT_W(CNT_W)) u_shift_x (
    .din   (x_q),
    .shamt (iter_q),
    .dout  (x_shift)
  );

  ashift #(.WIDTH(WIDTH), .SHIFT_W(CNT_W)) u_shift_y (
    .din   (y_q),
    .shamt (iter_q),
    .dout  (y_shift)
  );

  assign atan_val = WIDTH'(atan_entry(int'(iter_q), WIDTH));

  // d = +1 drives z toward zero (rotation) or pulls a negative y up (vectoring).
  assign rotate_pos = mode_q ? y_q[WIDTH-1] : ~z_q[WIDTH-1];

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    case (state_q)
      RUN: begin
        x_d = rotate_pos ? (x_q - y_shift)  : (x_q + y_shift);
        y_d = rotate_pos ? (y_q + x_shift)  : (y_q - x_shift);
        z_d = rotate_pos ? (z_q - atan_val) : (z_q + atan_val);
        if (iter_q == LAST_ITER) begin
          state_d = DONE;
        end else begin
          iter_d = iter_q + 1'b1;
        end
      end
      default: begin
        if (start) begin
          state_d = RUN;
          iter_d  = '0;
          mode_d  = mode;
          x_d     = x_in;
          y_d     = y_in;
          z_d     = z_in;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      iter_q  <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign x_out = x_q;
  assign y_out = y_q;
  assign z_out = z_q;

endmodule

// File: doc/cordic_engine.md
# cordic_engine

Iterative, parametrised CORDIC engine for the fixed-point trig datapath. It computes sin/cos in rotation mode and magnitude/phase in vectoring mode with one micro-rotation per clock. The direction of each micro-rotation comes from the sign of the angle or Y accumulator, not from an external input. It sits behind any sequencer that supplies operands with a start/done handshake. Width and iteration count are parameters.

## Interface
- WIDTH, 16: data and angle width; all values signed Q2.(WIDTH-2), angles in radians; legal 8..32.
- ITER, 14: micro-rotations per operation; legal 1..WIDTH-1.
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only when state is IDLE or DONE.
- mode  in  1  0 = rotation (drive z to 0), 1 = vectoring (drive y to 0); latched with operands.
- x_in, y_in, z_in  in  WIDTH each  operands; latched on accepted start.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse; results valid that cycle.
- x_out, y_out, z_out  out  WIDTH each  accumulator registers; hold until next accepted start.

## Operation
- States: IDLE, RUN, DONE.
- Accepted start: the edge where start=1 and state is IDLE or DONE.
  - x, y, z, mode load from the inputs; iteration counter i = 0; state becomes RUN.
- RUN, iteration i:
  - Let d = +1 when (mode=0 and z≥0) or (mode=1 and y<0); otherwise d = −1.
  - x' = x − d·(y>>>i)
  - y' = y + d·(x>>>i)
  - z' = z − d·atan(2^-i)
  - All three update on the same edge using pre-edge values.
  - Shifts are arithmetic.
  - Add/sub wraps modulo 2^WIDTH; there is no saturation.
- After the iteration with i = ITER−1, state becomes DONE. Otherwise i increments.
- DONE lasts one cycle with done=1.
  - With start=1, the start is accepted (back-to-back operation).
  - Otherwise, state becomes IDLE.
- start while in RUN is ignored: no effect, no queueing.
- Gain is not compensated. Rotation results scale by K≈1.6468. The caller pre-scales x_in by 1/K (0x26DD at WIDTH=16) for unit-amplitude sin/cos.
- Operand ranges:
  - Rotation: |z_in| ≤ 1.7432.
  - Vectoring: x_in > 0 and K·|(x,y)| < 2.0.
  - Results outside these ranges are undefined but must not hang the FSM.
- Results: rotation gives x_out ≈ cos, y_out ≈ sin, z_out ≈ 0. Vectoring gives x_out ≈ K·magnitude, y_out ≈ 0, z_out ≈ z_in + atan2(y,x).

## Timing
- Reset values: state IDLE; x, y, z, i, mode = 0; busy = 0; done = 0.
- Latency: start accepted at edge N → busy high N+1..N+ITER → done high during the cycle after edge N+ITER, i.e. ITER+1 cycles after acceptance.
- Throughput: one operation per ITER+1 cycles with back-to-back starts.
- Reset asserted mid-RUN: abort at that edge, return to reset values, no done pulse.
- Reset together with start: reset wins.
- x_out, y_out, z_out are the accumulator registers directly. They change during RUN and are valid only when done=1 and afterwards in IDLE.

## Structure
- Package cordic_pkg:
  - state enum (IDLE, RUN, DONE).
  - ATAN_Q30: 32-entry constant array of atan(2^-i) in Q2.30, rounded to nearest.
  - Function atan_entry(i, WIDTH): returns entry i rounded to Q2.(WIDTH-2) (round half up on dropped bits). For WIDTH=16, i=0 → 0x3244 and i=1 → 0x1DAC.
  - INV_K_Q30 constant for callers.
- Sub-module ashift #(WIDTH): combinational variable arithmetic right shifter (x>>>i). Two instances, for X and Y.
- Counter width: $clog2(ITER) with a minimum of 1.

## Test plan
- Rotation, WIDTH=16, ITER=14: x=0x26DD, y=0, z=0x3244 (π/4) → done at cycle 15; x_out, y_out = 0x2D41 ±4 LSB; |z_out| ≤ 4.
- Rotation, z=0: x=0x26DD, y=0 → x_out = 0x4000 ±4, y_out = 0 ±4. With z=0xCDBC (−π/4) → y_out = 0xD2BF ±4.
- Vectoring: x=0x2000, y=0x2000, z=0 → z_out = 0x3244 ±4; x_out = 0x4A87 ±6; |y_out| ≤ 4.
- Handshake: start pulsed at cycle 5 during RUN → ignored, single done pulse. Start held high through DONE → second operation begins with no IDLE cycle; new operands are latched.
- Reset asserted at RUN iteration 7 → next cycle busy=0, all outputs 0, no done; a following start completes normally.
- Parameter sweep WIDTH=24/ITER=22 and WIDTH=8/ITER=6: sin/cos vs. a real-valued model, error ≤ ITER LSB; done exactly ITER+1 cycles after start.
